// File: rtl/spi_reg_bridge.sv
// SPI mode-0 slave that turns 40-bit host frames (cmd, addr, data) into single-cycle
// register-file accesses; SPI is oversampled in clk_i, so there is no second clock domain.
//   state   | meaning
//   IDLE    | waiting for chip select
//   CMD     | shifting in the command byte (bits 1-8)
//   ADDR    | shifting in the address (bits 9-24)
//   RD_WAIT | read strobe issued, waiting for set_rd_data_en
//   DATA    | data phase (bits 25-40): write shift-in or read shift-out
//   DONE    | frame complete, SCLK ignored until CS deasserts
module spi_reg_bridge #(
  parameter int unsigned SYNC_STAGES  = 2,
  parameter logic [7:0]  CMD_WR       = 8'h02,
  parameter logic [7:0]  CMD_RD       = 8'h03,
  parameter logic [15:0] RD_FAIL_DATA = 16'hDEAD
) (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic        spi_sclk,
  input  logic        spi_cs_n,
  input  logic        spi_mosi,
  output logic        spi_miso,
  output logic        spi_miso_oe,
  output logic        set_wr_en,
  output logic [15:0] set_wr_addr,
  output logic [15:0] set_wr_data,
  output logic        set_rd_en,
  output logic [15:0] set_rd_addr,
  input  logic [15:0] set_rd_data,
  input  logic        set_rd_data_en,
  output logic        busy,
  output logic        frame_err
);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, RD_WAIT, DATA, DONE} state_t;

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync, settle;
  logic        sclk_d, armed;
  logic        sclk_s, cs_act, mosi_s, rise, fall;
  logic [5:0]  cnt;
  logic [15:0] rx_q, rx_next, tx_q, tx_word, addr_q;
  logic [7:0]  cmd_q;
  logic        miso_q;
  logic        is_rd, is_wr, past_cmd, in_frame;
  logic        cnt_clr, cmd_ld, addr_ld, wr_go, rd_go, err_go;
  logic        tx_ld_rd, tx_ld_fail, miso_shift;

  // CS chain resets to "deasserted" so miso_oe is 0 in reset; armed blocks a frame
  // start until CS has been seen high with a fully refilled synchroniser.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      settle    <= '0;
      sclk_d    <= 1'b0;
      armed     <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      settle    <= {settle[SYNC_STAGES-2:0], 1'b1};
      sclk_d    <= sclk_s;
      armed     <= armed | (settle[SYNC_STAGES-1] & cs_sync[SYNC_STAGES-1]);
    end
  end

  assign sclk_s  = sclk_sync[SYNC_STAGES-1];
  assign cs_act  = ~cs_sync[SYNC_STAGES-1];
  assign mosi_s  = mosi_sync[SYNC_STAGES-1];
  assign rise    = sclk_s & ~sclk_d;
  assign fall    = ~sclk_s & sclk_d;
  assign rx_next = {rx_q[14:0], mosi_s};

  assign is_rd    = (cmd_q == CMD_RD);
  assign is_wr    = (cmd_q == CMD_WR);
  assign past_cmd = state inside {ADDR, RD_WAIT, DATA, DONE};
  assign in_frame = state inside {CMD, ADDR, RD_WAIT, DATA};

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state <= IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    cnt_clr    = 1'b0;
    cmd_ld     = 1'b0;
    addr_ld    = 1'b0;
    wr_go      = 1'b0;
    rd_go      = 1'b0;
    err_go     = 1'b0;
    tx_ld_rd   = 1'b0;
    tx_ld_fail = 1'b0;
    case (state)
      IDLE: begin
        if (armed && cs_act) begin
          state_nxt = CMD;
          cnt_clr   = 1'b1;
        end
      end
      CMD: begin
        if (rise && cnt == 6'd7) begin
          cmd_ld    = 1'b1;
          state_nxt = ADDR;
        end
      end
      ADDR: begin
        if (rise && cnt == 6'd23) begin
          addr_ld = 1'b1;
          if (is_rd) begin
            rd_go     = 1'b1;
            state_nxt = RD_WAIT;
          end else begin
            state_nxt = DATA;
          end
        end
      end
      RD_WAIT: begin
        if (set_rd_data_en) begin
          tx_ld_rd  = 1'b1;
          state_nxt = DATA;
        end else if (fall && cnt == 6'd24) begin
          tx_ld_fail = 1'b1;
          err_go     = 1'b1;
          state_nxt  = DATA;
        end
      end
      DATA: begin
        if (rise && cnt == 6'd39) begin
          wr_go     = is_wr;
          state_nxt = DONE;
        end
      end
      DONE: ;
      default: state_nxt = IDLE;
    endcase
    // CS release wins over everything, including a 40th edge seen in the same cycle.
    if (state != IDLE && !cs_act) begin
      state_nxt  = IDLE;
      wr_go      = 1'b0;
      rd_go      = 1'b0;
      tx_ld_rd   = 1'b0;
      tx_ld_fail = 1'b0;
      err_go     = (cnt != 6'd0 && cnt != 6'd40) || (past_cmd && !is_rd && !is_wr);
    end
  end

  assign tx_word    = tx_ld_rd ? set_rd_data : (tx_ld_fail ? RD_FAIL_DATA : tx_q);
  assign miso_shift = fall && (cnt >= 6'd24) &&
                      ((state == DATA && is_rd) || tx_ld_rd || tx_ld_fail);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cnt         <= '0;
      rx_q        <= '0;
      tx_q        <= '0;
      cmd_q       <= '0;
      addr_q      <= '0;
      miso_q      <= 1'b0;
      set_wr_en   <= 1'b0;
      set_wr_addr <= '0;
      set_wr_data <= '0;
      set_rd_en   <= 1'b0;
      set_rd_addr <= '0;
      frame_err   <= 1'b0;
    end else begin
      set_wr_en <= wr_go;
      set_rd_en <= rd_go;
      frame_err <= err_go;
      if (cnt_clr) begin
        cnt  <= '0;
        rx_q <= '0;
      end else if (rise && in_frame) begin
        cnt  <= cnt + 6'd1;
        rx_q <= rx_next;
      end
      if (cmd_ld)  cmd_q  <= rx_next[7:0];
      if (addr_ld) addr_q <= rx_next;
      if (rd_go)   set_rd_addr <= rx_next;
      if (wr_go) begin
        set_wr_addr <= addr_q;
        set_wr_data <= rx_next;
      end
      if (state == IDLE) begin
        tx_q   <= '0;
        miso_q <= 1'b0;
      end else if (miso_shift) begin
        miso_q <= tx_word[15];
        tx_q   <= {tx_word[14:0], 1'b0};
      end else if (tx_ld_rd) begin
        tx_q <= set_rd_data;
      end
    end
  end

  assign spi_miso    = (state == DATA && is_rd) ? miso_q : 1'b0;
  assign spi_miso_oe = cs_act;
  assign busy        = (state != IDLE);

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Self-checking bench for spi_reg_bridge: bench acts as SPI host and as a simple
// register file, and compares frame outcomes against frame-level expectations.
module tb_spi_reg_bridge;
  localparam int HP = 8;

  logic        clk_i = 1'b0;
  logic        reset_n_i = 1'b0;
  logic        spi_sclk = 1'b0;
  logic        spi_cs_n = 1'b1;
  logic        spi_mosi = 1'b0;
  logic        spi_miso, spi_miso_oe;
  logic        set_wr_en, set_rd_en, busy, frame_err;
  logic [15:0] set_wr_addr, set_wr_data, set_rd_addr;
  logic [15:0] set_rd_data = 16'h0;
  logic        set_rd_data_en = 1'b0;

  int checks = 0;
  int failures = 0;
  int wr_cnt = 0, rd_cnt = 0, err_cnt = 0, miso_hi_cnt = 0;
  logic [15:0] last_wr_addr = '0, last_wr_data = '0, last_rd_addr = '0;
  logic        rf_respond = 1'b1;
  logic [15:0] rf_mem [int];
  logic [15:0] model_mem [int];

  spi_reg_bridge dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i),
    .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
    .set_wr_en(set_wr_en), .set_wr_addr(set_wr_addr), .set_wr_data(set_wr_data),
    .set_rd_en(set_rd_en), .set_rd_addr(set_rd_addr),
    .set_rd_data(set_rd_data), .set_rd_data_en(set_rd_data_en),
    .busy(busy), .frame_err(frame_err)
  );

  always #5 clk_i = ~clk_i;

  // Bus monitor plus register-file stub answering one cycle after set_rd_en.
  always @(negedge clk_i) begin
    set_rd_data_en = 1'b0;
    if (set_wr_en) begin
      wr_cnt++;
      last_wr_addr = set_wr_addr;
      last_wr_data = set_wr_data;
      rf_mem[int'(set_wr_addr)] = set_wr_data;
    end
    if (set_rd_en) begin
      rd_cnt++;
      last_rd_addr = set_rd_addr;
      if (rf_respond) begin
        set_rd_data_en = 1'b1;
        set_rd_data = rf_mem.exists(int'(set_rd_addr)) ? rf_mem[int'(set_rd_addr)] : 16'h0;
      end
    end
    if (frame_err) err_cnt++;
    if (spi_miso)  miso_hi_cnt++;
  end

  task automatic cs_assert();
    @(negedge clk_i);
    spi_cs_n = 1'b0;
    repeat (HP) @(negedge clk_i);
  endtask

  task automatic shift_bits(input logic [39:0] f, input int nbits, output logic [15:0] mw);
    mw = '0;
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = f[39-i];
      repeat (HP) @(negedge clk_i);
      if (i >= 24) mw[39-i] = spi_miso;
      spi_sclk = 1'b1;
      repeat (HP) @(negedge clk_i);
      spi_sclk = 1'b0;
    end
  endtask

  task automatic cs_deassert();
    repeat (HP) @(negedge clk_i);
    spi_cs_n = 1'b1;
    spi_mosi = 1'b0;
    repeat (12) @(negedge clk_i);
  endtask

  task automatic do_frame(input logic [39:0] f, input int nbits, output logic [15:0] mw,
                          output int dwr, output int drd, output int derr);
    int w0, r0, e0;
    w0 = wr_cnt; r0 = rd_cnt; e0 = err_cnt;
    cs_assert();
    shift_bits(f, nbits, mw);
    cs_deassert();
    dwr = wr_cnt - w0; drd = rd_cnt - r0; derr = err_cnt - e0;
  endtask

  task automatic test_reset();
    reset_n_i = 1'b0;
    repeat (3) @(negedge clk_i);
    checks++;
    if ({set_wr_en, set_rd_en, busy, frame_err, spi_miso, spi_miso_oe} !== 6'b0) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=000000",
               {set_wr_en, set_rd_en, busy, frame_err, spi_miso, spi_miso_oe});
    end
    checks++;
    if ({set_wr_addr, set_wr_data, set_rd_addr} !== 48'h0) begin
      failures++;
      $display("FAIL reset_bus got=%h exp=0", {set_wr_addr, set_wr_data, set_rd_addr});
    end
    reset_n_i = 1'b1;
    repeat (10) @(negedge clk_i);
  endtask

  task automatic test_write();
    logic [15:0] mw;
    int w0, e0;
    w0 = wr_cnt; e0 = err_cnt;
    cs_assert();
    checks++;
    if ({busy, spi_miso_oe} !== 2'b11) begin
      failures++;
      $display("FAIL wr_busy_oe got=%b exp=11", {busy, spi_miso_oe});
    end
    shift_bits({8'h02, 16'h0010, 16'h0005}, 40, mw);
    cs_deassert();
    checks++;
    if (wr_cnt - w0 != 1 || last_wr_addr !== 16'h0010 || last_wr_data !== 16'h0005) begin
      failures++;
      $display("FAIL wr_basic got n=%0d a=%h d=%h exp n=1 a=0010 d=0005",
               wr_cnt - w0, last_wr_addr, last_wr_data);
    end
    checks++;
    if ({busy, spi_miso_oe} !== 2'b00 || err_cnt != e0) begin
      failures++;
      $display("FAIL wr_end got busy_oe=%b err=%0d exp 00 err=0", {busy, spi_miso_oe}, err_cnt - e0);
    end
  endtask

  task automatic test_read();
    logic [15:0] mw;
    int dwr, drd, derr;
    rf_mem[16'h0013] = 16'h1234;
    rf_respond = 1'b1;
    do_frame({8'h03, 16'h0013, 16'($urandom)}, 40, mw, dwr, drd, derr);
    checks++;
    if (drd != 1 || last_rd_addr !== 16'h0013 || dwr != 0) begin
      failures++;
      $display("FAIL rd_strobe got rd=%0d a=%h wr=%0d exp rd=1 a=0013 wr=0", drd, last_rd_addr, dwr);
    end
    checks++;
    if (mw !== 16'h1234 || derr != 0) begin
      failures++;
      $display("FAIL rd_data got miso=%h err=%0d exp 1234 err=0", mw, derr);
    end
  endtask

  task automatic test_read_timeout();
    logic [15:0] mw;
    int dwr, drd, derr;
    rf_respond = 1'b0;
    do_frame({8'h03, 16'h0021, 16'h0000}, 40, mw, dwr, drd, derr);
    rf_respond = 1'b1;
    checks++;
    if (mw !== 16'hDEAD || derr != 1 || drd != 1) begin
      failures++;
      $display("FAIL rd_timeout got miso=%h err=%0d rd=%0d exp DEAD err=1 rd=1", mw, derr, drd);
    end
  endtask

  task automatic test_abort();
    logic [15:0] mw;
    int dwr, drd, derr;
    do_frame({8'h02, 16'h0030, 16'h7777}, 30, mw, dwr, drd, derr);
    checks++;
    if (dwr != 0 || derr != 1) begin
      failures++;
      $display("FAIL abort got wr=%0d err=%0d exp wr=0 err=1", dwr, derr);
    end
    do_frame({8'h02, 16'h0042, 16'hA5C3}, 40, mw, dwr, drd, derr);
    checks++;
    if (dwr != 1 || derr != 0 || last_wr_addr !== 16'h0042 || last_wr_data !== 16'hA5C3) begin
      failures++;
      $display("FAIL after_abort got wr=%0d err=%0d a=%h d=%h exp 1 0 0042 A5C3",
               dwr, derr, last_wr_addr, last_wr_data);
    end
  endtask

  task automatic test_unknown_cmd();
    logic [15:0] mw;
    int dwr, drd, derr, m0;
    m0 = miso_hi_cnt;
    do_frame({8'h55, 16'hFFFF, 16'hFFFF}, 40, mw, dwr, drd, derr);
    checks++;
    if (dwr != 0 || drd != 0 || derr != 1 || miso_hi_cnt != m0) begin
      failures++;
      $display("FAIL unknown_cmd got wr=%0d rd=%0d err=%0d miso_hi=%0d exp 0 0 1 0",
               dwr, drd, derr, miso_hi_cnt - m0);
    end
  endtask

  task automatic test_cs_at_last_edge();
    logic [15:0] mw;
    logic [39:0] f;
    int w0, e0;
    f = {8'h02, 16'h0050, 16'h1111};
    w0 = wr_cnt; e0 = err_cnt;
    cs_assert();
    shift_bits(f, 39, mw);
    spi_mosi = f[0];
    repeat (HP) @(negedge clk_i);
    spi_sclk = 1'b1;
    spi_cs_n = 1'b1;
    repeat (HP) @(negedge clk_i);
    spi_sclk = 1'b0;
    repeat (12) @(negedge clk_i);
    checks++;
    if (wr_cnt != w0 || err_cnt - e0 != 1) begin
      failures++;
      $display("FAIL cs_last_edge got wr=%0d err=%0d exp wr=0 err=1", wr_cnt - w0, err_cnt - e0);
    end
  endtask

  task automatic test_reset_midframe();
    logic [15:0] mw;
    int dwr, drd, derr, w0;
    w0 = wr_cnt;
    cs_assert();
    shift_bits({8'h02, 16'h0060, 16'h2222}, 20, mw);
    reset_n_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if ({set_wr_en, set_rd_en, busy, frame_err, spi_miso, spi_miso_oe} !== 6'b0 ||
        {set_wr_addr, set_wr_data, set_rd_addr} !== 48'h0) begin
      failures++;
      $display("FAIL midframe_reset got ctrl=%b bus=%h exp 0",
               {set_wr_en, set_rd_en, busy, frame_err, spi_miso, spi_miso_oe},
               {set_wr_addr, set_wr_data, set_rd_addr});
    end
    spi_cs_n = 1'b1;
    repeat (4) @(negedge clk_i);
    reset_n_i = 1'b1;
    repeat (10) @(negedge clk_i);
    checks++;
    if (busy !== 1'b0 || wr_cnt != w0) begin
      failures++;
      $display("FAIL post_reset_idle got busy=%b wr=%0d exp 0 0", busy, wr_cnt - w0);
    end
    do_frame({8'h02, 16'h0077, 16'hBEEF}, 40, mw, dwr, drd, derr);
    checks++;
    if (dwr != 1 || derr != 0 || last_wr_addr !== 16'h0077 || last_wr_data !== 16'hBEEF) begin
      failures++;
      $display("FAIL post_reset_write got wr=%0d err=%0d a=%h d=%h exp 1 0 0077 BEEF",
               dwr, derr, last_wr_addr, last_wr_data);
    end
  endtask

  // Random back-to-back writes and reads to a private address window; the model is a
  // plain memory of what each write frame should have stored.
  task automatic test_random();
    logic [15:0] mw, a, d, exp_rd;
    int dwr, drd, derr;
    bit is_wr;
    for (int n = 0; n < 10; n++) begin
      a = 16'h0100 + 16'($urandom_range(0, 3));
      d = 16'($urandom);
      is_wr = (n < 2) || ($urandom_range(0, 1) == 1);
      if (is_wr) begin
        do_frame({8'h02, a, d}, 40, mw, dwr, drd, derr);
        model_mem[int'(a)] = d;
        checks++;
        if (dwr != 1 || drd != 0 || derr != 0 || last_wr_addr !== a || last_wr_data !== d) begin
          failures++;
          $display("FAIL rand_wr[%0d] got wr=%0d rd=%0d err=%0d a=%h d=%h exp 1 0 0 %h %h",
                   n, dwr, drd, derr, last_wr_addr, last_wr_data, a, d);
        end
      end else begin
        exp_rd = model_mem.exists(int'(a)) ? model_mem[int'(a)] : 16'h0;
        do_frame({8'h03, a, d}, 40, mw, dwr, drd, derr);
        checks++;
        if (drd != 1 || dwr != 0 || derr != 0 || last_rd_addr !== a || mw !== exp_rd) begin
          failures++;
          $display("FAIL rand_rd[%0d] got rd=%0d wr=%0d err=%0d a=%h miso=%h exp 1 0 0 %h %h",
                   n, drd, dwr, derr, last_rd_addr, mw, a, exp_rd);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_read_timeout();
    test_abort();
    test_unknown_cmd();
    test_cs_at_last_edge();
    test_reset_midframe();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
